// File: rtl/tff_counter_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tff_ctrl_pkg : shared state and direction encodings for tff_counter_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
package tff_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } tff_state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/t_ff.sv
`default_nettype none
// ---------------------------------------------------------------------------
// t_ff : single toggle flip-flop with asynchronous active-low reset
// Revision: 1.0
// ---------------------------------------------------------------------------
module t_ff (
   input  logic t,
   input  logic clk,
   input  logic rst,
   output logic q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= 1'b0;
      end else if (t) begin
         q <= ~q;
      end
   end

endmodule
`default_nettype wire

// File: rtl/tff_counter_ctrl_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tff_counter_ctrl_bank : WIDTH t_ff cells sharing one clock and reset
// Revision: 1.0
// ---------------------------------------------------------------------------
module tff_counter_ctrl_bank #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] t_vec_i,
   output logic [WIDTH-1:0] q_o
);

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_cell
         t_ff u_t_ff (
            .t   (t_vec_i[i]),
            .clk (clk),
            .rst (rst),
            .q   (q_o[i])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/tff_counter_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tff_counter_ctrl : sequences a t_ff bank as a loadable bounded up/down counter
// Revision: 1.0
// ---------------------------------------------------------------------------
module tff_counter_ctrl
   import tff_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             dir,
   input  logic [WIDTH-1:0] limit,
   input  logic             load_req,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] t_vec,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   tff_state_t       state_q, state_d;
   logic             dir_q;
   logic [WIDTH-1:0] limit_q;
   logic [WIDTH-1:0] load_val_q;
   logic             terminal;

   // Bit i toggles when every lower bit is 1 (up) or 0 (down): ripple of +/-1.
   function automatic logic [WIDTH-1:0] step_toggles(input logic [WIDTH-1:0] v,
                                                     input logic             down);
      logic [WIDTH-1:0] t;
      logic             carry;
      carry = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         t[i]  = carry;
         carry = carry & ((down == DIR_UP) ? v[i] : ~v[i]);
      end
      return t;
   endfunction

   tff_counter_ctrl_bank #(
      .WIDTH (WIDTH)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .t_vec_i (t_vec),
      .q_o     (q)
   );

   assign terminal = (dir_q == DIR_DOWN) ? (q == '0) : (q == limit_q);

   always_comb begin
      state_d = state_q;
      t_vec   = '0;
      tc      = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_req) begin
               state_d = LOAD;
            end else if (start) begin
               state_d = RUN;
            end
         end
         LOAD: begin
            t_vec   = q ^ load_val_q;
            state_d = IDLE;
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (terminal) begin
               tc      = 1'b1;
               state_d = DONE;
            end else begin
               t_vec = step_toggles(q, dir_q);
            end
         end
         DONE: begin
            if (load_req) begin
               state_d = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == LOAD) || (state_q == RUN);
   assign done = (state_q == DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         dir_q      <= DIR_UP;
         limit_q    <= '0;
         load_val_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) begin
            if (load_req) begin
               load_val_q <= load_val;
            end else if (start) begin
               dir_q   <= dir;
               limit_q <= limit;
            end
         end else if ((state_q == DONE) && load_req) begin
            load_val_q <= load_val;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tff_counter_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tff_counter_ctrl : directed and randomized checks of tff_counter_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_tff_counter_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0, stop = 1'b0, dir = 1'b0, load_req = 1'b0;
   logic [W-1:0] limit = '0, load_val = '0;
   logic [W-1:0] q, t_vec;
   logic         busy, tc, done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tff_counter_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .dir      (dir),
      .limit    (limit),
      .load_req (load_req),
      .load_val (load_val),
      .q        (q),
      .t_vec    (t_vec),
      .busy     (busy),
      .tc       (tc),
      .done     (done)
   );

   // Bits that differ between v and its successor/predecessor modulo 2^W.
   function automatic logic [W-1:0] exp_toggle(input logic [W-1:0] v, input logic down);
      logic [W-1:0] nx;
      nx = down ? v - 1'b1 : v + 1'b1;
      return v ^ nx;
   endfunction

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic do_load(input logic [W-1:0] v);
      load_req = 1'b1; load_val = v; nxt();
      load_req = 1'b0; load_val = W'($urandom); nxt();
   endtask

   task automatic start_run(input logic d, input logic [W-1:0] lim);
      dir = d; limit = lim; start = 1'b1; nxt();
      start = 1'b0; dir = 1'($urandom); limit = W'($urandom);
   endtask

   task automatic test_reset();
      nxt(); nxt(); #1;
      total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h want=00", q); end
      total++; if ({busy, tc, done} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, tc, done}); end
      total++; if (t_vec !== 8'h00) begin bad++; $display("FAIL reset_tvec got=%h want=00", t_vec); end
      rst = 1'b1; nxt();
      start_run(1'b0, 8'd9);
      nxt(); nxt(); nxt(); #1;
      total++; if (q !== 8'h03) begin bad++; $display("FAIL pre_reset_q got=%h want=03", q); end
      #1 rst = 1'b0; #1;
      total++; if (q !== 8'h00) begin bad++; $display("FAIL midrun_reset_q got=%h want=00", q); end
      total++; if ({busy, tc, done} !== 3'b000) begin bad++; $display("FAIL midrun_reset_flags got=%b want=000", {busy, tc, done}); end
      nxt(); rst = 1'b1; nxt(); #1;
      total++; if (q !== 8'h00 || busy !== 1'b0 || t_vec !== 8'h00) begin
         bad++; $display("FAIL post_reset_idle got q=%h busy=%b t=%h want q=00 busy=0 t=00", q, busy, t_vec); end
   endtask

   task automatic test_load();
      load_req = 1'b1; load_val = 8'hA5; nxt();
      load_req = 1'b0; load_val = 8'h00; #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL load_busy got=%b want=1", busy); end
      total++; if (t_vec !== 8'hA5) begin bad++; $display("FAIL load_tvec got=%h want=a5", t_vec); end
      nxt(); #1;
      total++; if (q !== 8'hA5 || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL load_result got q=%h busy=%b done=%b want q=a5 busy=0 done=0", q, busy, done); end
      nxt(); #1;
      total++; if (q !== 8'hA5) begin bad++; $display("FAIL load_hold got=%h want=a5", q); end
   endtask

   // Runs a count from a toward its terminal and checks every cycle against
   // plain +/- arithmetic; stop_at beyond the run length means no stop.
   task automatic run_check(input logic [W-1:0] a, input logic [W-1:0] lim,
                            input logic d, input int stop_at);
      int           n_end;
      logic [W-1:0] eq;
      logic [W-1:0] term;
      bit           stopped;
      stopped = 0;
      n_end = d ? int'(a) : ((int'(lim) - int'(a)) & ((1 << W) - 1));
      term  = d ? '0 : lim;
      start_run(d, lim);
      for (int n = 0; n <= n_end; n++) begin
         eq = d ? W'(int'(a) - n) : W'(int'(a) + n);
         dir = 1'($urandom); limit = W'($urandom);
         if (n == stop_at) begin
            stop = 1'b1; start = 1'b0; load_req = 1'b0; #1;
            total++; if (tc !== 1'b0 || t_vec !== 8'h00) begin
               bad++; $display("FAIL stop_cycle n=%0d got tc=%b t=%h want tc=0 t=00", n, tc, t_vec); end
            nxt(); stop = 1'b0; #1;
            total++; if (busy !== 1'b0 || done !== 1'b0 || q !== eq) begin
               bad++; $display("FAIL after_stop got q=%h busy=%b done=%b want q=%h busy=0 done=0", q, busy, done, eq); end
            stopped = 1;
            break;
         end
         start = 1'($urandom); load_req = 1'($urandom); #1;
         total++; if (q !== eq || tc !== (n == n_end) || busy !== 1'b1) begin
            bad++; $display("FAIL run_cycle n=%0d got q=%h tc=%b busy=%b want q=%h tc=%b busy=1", n, q, tc, busy, eq, (n == n_end)); end
         total++; if (t_vec !== ((n == n_end) ? 8'h00 : exp_toggle(eq, d))) begin
            bad++; $display("FAIL run_tvec n=%0d got=%h want=%h", n, t_vec, (n == n_end) ? 8'h00 : exp_toggle(eq, d)); end
         nxt();
      end
      start = 1'b0; load_req = 1'b0;
      if (!stopped) begin
         #1;
         total++; if (done !== 1'b1 || busy !== 1'b0 || tc !== 1'b0 || q !== term) begin
            bad++; $display("FAIL run_done got q=%h done=%b busy=%b tc=%b want q=%h done=1 busy=0 tc=0", q, done, busy, tc, term); end
         nxt();
      end
   endtask

   task automatic test_count_up();
      do_load(8'h00);
      run_check(8'h00, 8'h05, 1'b0, 1000);
      #1;
      total++; if (q !== 8'h05 || done !== 1'b1) begin bad++; $display("FAIL up_hold got q=%h done=%b want q=05 done=1", q, done); end
   endtask

   task automatic test_count_down();
      do_load(8'h03);
      run_check(8'h03, W'($urandom), 1'b1, 1000);
      start = 1'b1; nxt(); start = 1'b0; #1;
      total++; if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h00) begin
         bad++; $display("FAIL done_ignores_start got q=%h done=%b busy=%b want q=00 done=1 busy=0", q, done, busy); end
      load_req = 1'b1; load_val = 8'h00; nxt(); load_req = 1'b0; #1;
      total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL done_load_busy got busy=%b done=%b want 1 0", busy, done); end
      nxt(); #1;
      total++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL done_load_idle got q=%h busy=%b done=%b want q=00 busy=0 done=0", q, busy, done); end
   endtask

   task automatic test_wrap();
      do_load(8'hFE);
      run_check(8'hFE, 8'h01, 1'b0, 1000);
   endtask

   task automatic test_stop();
      do_load(8'h00);
      run_check(8'h00, 8'h09, 1'b0, 3);
      nxt(); #1;
      total++; if (q !== 8'h03 || busy !== 1'b0) begin bad++; $display("FAIL stop_hold got q=%h busy=%b want q=03 busy=0", q, busy); end
      run_check(8'h03, 8'h05, 1'b0, 2);
   endtask

   task automatic test_load_start_same();
      load_req = 1'b1; start = 1'b1; load_val = 8'h3C; dir = 1'b0; limit = 8'hFF; nxt();
      load_req = 1'b0; start = 1'b0; #1;
      total++; if (busy !== 1'b1 || t_vec !== (8'h05 ^ 8'h3C)) begin
         bad++; $display("FAIL both_load got busy=%b t=%h want busy=1 t=%h", busy, t_vec, 8'h05 ^ 8'h3C); end
      nxt(); #1;
      total++; if (q !== 8'h3C || busy !== 1'b0) begin bad++; $display("FAIL both_result got q=%h busy=%b want q=3c busy=0", q, busy); end
      nxt(); #1;
      total++; if (q !== 8'h3C || busy !== 1'b0) begin bad++; $display("FAIL both_no_run got q=%h busy=%b want q=3c busy=0", q, busy); end
   endtask

   task automatic test_random();
      logic [W-1:0] a, lim;
      logic         d;
      int           span, sa;
      for (int it = 0; it < 20; it++) begin
         a   = W'($urandom);
         lim = W'($urandom);
         d   = 1'($urandom);
         span = d ? int'(a) : ((int'(lim) - int'(a)) & ((1 << W) - 1));
         sa   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, span)) : 1000;
         do_load(a);
         run_check(a, lim, d, sa);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_count_up();
      test_count_down();
      test_wrap();
      test_stop();
      test_load_start_same();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
